// File: rtl/xor4_gate_pkg.sv
// ----------------------------------------------------------------------------
// xor4_gate_pkg
// Shared constants and helpers for the registered 4-input XOR parity cell.
//   N_IN       number of parity inputs (fixed at 4)
//   CNT_W      width of the ones-count output (holds 0..4)
//   F_RST      reset value of the registered parity
//   CNT_RST    reset value of the registered ones-count
//   count_ones zero-extended population count of an N_IN-bit vector
// ----------------------------------------------------------------------------
package xor4_gate_pkg;

   localparam int N_IN  = 4;
   localparam int CNT_W = 3;

   localparam logic             F_RST   = 1'b0;
   localparam logic [CNT_W-1:0] CNT_RST = '0;

   function automatic logic [CNT_W-1:0] count_ones(input logic [N_IN-1:0] v);
      logic [CNT_W-1:0] s;
      s = '0;
      for (int i = 0; i < N_IN; i++) begin
         s = s + {{(CNT_W-1){1'b0}}, v[i]};
      end
      return s;
   endfunction

endpackage : xor4_gate_pkg

// File: rtl/xor4_gate_core.sv
// ----------------------------------------------------------------------------
// xor4_gate_core
// Purely combinational parity / ones-count of four input bits.
//   i_a..i_d  input bits, i_a is the MSB of {a,b,c,d}
//   o_f       a ^ b ^ c ^ d (1 when an odd number of inputs are set)
//   o_cnt     number of set inputs, 0..4
// ----------------------------------------------------------------------------
module xor4_gate_core
   import xor4_gate_pkg::*;
(
   input  logic             i_a,
   input  logic             i_b,
   input  logic             i_c,
   input  logic             i_d,
   output logic             o_f,
   output logic [CNT_W-1:0] o_cnt
);

   logic [N_IN-1:0] vec;

   assign vec   = {i_a, i_b, i_c, i_d};
   assign o_f   = i_a ^ i_b ^ i_c ^ i_d;
   assign o_cnt = count_ones(vec);

endmodule : xor4_gate_core

// File: rtl/xor4_gate_equation.sv
// ----------------------------------------------------------------------------
// xor4_gate_equation
// Registered 4-input XOR (odd parity) cell with a ones-count side output and
// a combinational parity copy for same-cycle consumers.
//   i_clk     rising-edge clock
//   i_rst     synchronous active-high reset (clears all registered outputs)
//   i_a..i_d  input bits, i_a is the MSB of {a,b,c,d}
//   o_f_comb  combinational a^b^c^d, never reset
//   o_f       registered parity
//   o_cnt     registered ones-count (0..4)
//   o_valid   high once the registered outputs hold a post-reset sample
// Build option:
//   XOR4_GATE_EQUATION_PIPE_EN  adds a second register stage (latency 2);
//                               undefined gives a single stage (latency 1).
// ----------------------------------------------------------------------------
module xor4_gate_equation
   import xor4_gate_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_a,
   input  logic             i_b,
   input  logic             i_c,
   input  logic             i_d,
   output logic             o_f_comb,
   output logic             o_f,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_valid
);

   logic             f_p0;
   logic [CNT_W-1:0] cnt_p0;

   xor4_gate_core u_core (
      .i_a   (i_a),
      .i_b   (i_b),
      .i_c   (i_c),
      .i_d   (i_d),
      .o_f   (f_p0),
      .o_cnt (cnt_p0)
   );

   assign o_f_comb = f_p0;

   // ---- stage p0 -> p1: first register stage ----
   logic             f_p1;
   logic [CNT_W-1:0] cnt_p1;
   logic             vld_p1;

   // Data is reset here as well so the outputs are defined from the first
   // reset edge, even while the inputs are still unknown.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         f_p1   <= F_RST;
         cnt_p1 <= CNT_RST;
         vld_p1 <= 1'b0;
      end else begin
         f_p1   <= f_p0;
         cnt_p1 <= cnt_p0;
         vld_p1 <= 1'b1;
      end
   end

`ifdef XOR4_GATE_EQUATION_PIPE_EN
   // ---- stage p1 -> p2: optional second register stage ----
   logic             f_p2;
   logic [CNT_W-1:0] cnt_p2;
   logic             vld_p2;

   // Reset clears this stage too, so a sample caught in p1 at reset is lost.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         f_p2   <= F_RST;
         cnt_p2 <= CNT_RST;
         vld_p2 <= 1'b0;
      end else begin
         f_p2   <= f_p1;
         cnt_p2 <= cnt_p1;
         vld_p2 <= vld_p1;
      end
   end

   assign o_f     = f_p2;
   assign o_cnt   = cnt_p2;
   assign o_valid = vld_p2;
`else
   assign o_f     = f_p1;
   assign o_cnt   = cnt_p1;
   assign o_valid = vld_p1;
`endif

endmodule : xor4_gate_equation

// File: tb/tb_xor4_gate_equation.sv
// ----------------------------------------------------------------------------
// tb_xor4_gate_equation
// Self-checking bench for xor4_gate_equation. A reference model derives the
// expected registered outputs from the history of applied edges: if any of
// the last LAT edges had reset asserted the outputs are zero, otherwise they
// reflect the vector applied LAT edges ago.
// ----------------------------------------------------------------------------
module tb_xor4_gate_equation;

`ifdef XOR4_GATE_EQUATION_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       i_clk;
   logic       i_rst;
   logic       i_a, i_b, i_c, i_d;
   logic       o_f_comb;
   logic       o_f;
   logic [2:0] o_cnt;
   logic       o_valid;

   int n_checks = 0;
   int n_fail   = 0;

   bit         rst_q[$];
   logic [3:0] vec_q[$];

   typedef struct {
      logic       f;
      logic [2:0] cnt;
      logic       vld;
   } exp_t;

   xor4_gate_equation dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_a      (i_a),
      .i_b      (i_b),
      .i_c      (i_c),
      .i_d      (i_d),
      .o_f_comb (o_f_comb),
      .o_f      (o_f),
      .o_cnt    (o_cnt),
      .o_valid  (o_valid)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   function automatic int popcnt(input logic [3:0] v);
      int n = 0;
      for (int i = 0; i < 4; i++) n += (v[i] === 1'b1) ? 1 : 0;
      return n;
   endfunction

   function automatic exp_t model();
      exp_t       e;
      logic [3:0] v;
      int         sz;
      e.f = 1'b0; e.cnt = 3'd0; e.vld = 1'b0;
      sz = rst_q.size();
      if (sz < LAT) return e;
      for (int k = 0; k < LAT; k++) if (rst_q[sz-1-k]) return e;
      v     = vec_q[sz-LAT];
      e.cnt = 3'(popcnt(v));
      e.f   = (popcnt(v) % 2) == 1;
      e.vld = 1'b1;
      return e;
   endfunction

   // Apply one vector across one rising edge, record it, sample #1 later.
   task automatic edge_step(input bit rst, input logic [3:0] v);
      i_rst = rst;
      {i_a, i_b, i_c, i_d} = v;
      @(posedge i_clk);
      rst_q.push_back(rst);
      vec_q.push_back(v);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      @(negedge i_clk);
      edge_step(1'b1, 4'bxxxx);
      edge_step(1'b1, 4'bxxxx);
      n_checks++;
      if ({o_f, o_cnt, o_valid} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_x: f/cnt/vld got %b/%0d/%b, required 0/0/0", o_f, o_cnt, o_valid);
      end
      {i_a, i_b, i_c, i_d} = 4'b1111;
      #1;
      n_checks++;
      if (o_f_comb !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_comb: o_f_comb got %b, required 0", o_f_comb);
      end
      edge_step(1'b1, 4'b1111);
      e = model();
      n_checks++;
      if ({o_f, o_cnt, o_valid} !== {e.f, e.cnt, e.vld} || o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_1111: f/cnt/vld got %b/%0d/%b, required 0/0/0", o_f, o_cnt, o_valid);
      end
   endtask

   // 0000..1111 then 0000, 0001: parity, popcount and wrap-around.
   task automatic test_count();
      exp_t       e;
      logic [3:0] v;
      for (int i = 0; i < 18 + LAT; i++) begin
         v = 4'(i % 16);
         {i_a, i_b, i_c, i_d} = v;
         #1;
         n_checks++;
         if (o_f_comb !== 1'((popcnt(v) % 2))) begin
            n_fail++;
            $display("FAIL count_comb[%0d]: o_f_comb got %b, required %0d", i, o_f_comb, popcnt(v) % 2);
         end
         edge_step(1'b0, v);
         e = model();
         n_checks++;
         if ({o_f, o_cnt, o_valid} !== {e.f, e.cnt, e.vld}) begin
            n_fail++;
            $display("FAIL count[%0d]: f/cnt/vld got %b/%0d/%b, required %b/%0d/%b",
                     i, o_f, o_cnt, o_valid, e.f, e.cnt, e.vld);
         end
         n_checks++;
         if (o_valid === 1'b1 && o_f !== o_cnt[0]) begin
            n_fail++;
            $display("FAIL invariant[%0d]: o_f got %b, required o_cnt[0]=%b", i, o_f, o_cnt[0]);
         end
      end
   endtask

   task automatic test_comb_path();
      exp_t e;
      for (int k = 0; k < LAT; k++) edge_step(1'b0, 4'b0000);
      #2;
      {i_a, i_b, i_c, i_d} = 4'b1000;
      #1;
      n_checks++;
      if (o_f_comb !== 1'b1) begin
         n_fail++;
         $display("FAIL comb_mid: o_f_comb got %b, required 1", o_f_comb);
      end
      n_checks++;
      if (o_f !== 1'b0) begin
         n_fail++;
         $display("FAIL comb_hold: o_f got %b, required 0", o_f);
      end
      for (int k = 0; k < LAT; k++) edge_step(1'b0, 4'b1000);
      e = model();
      n_checks++;
      if (o_f !== 1'b1 || o_cnt !== 3'd1 || e.cnt !== 3'd1) begin
         n_fail++;
         $display("FAIL comb_reg: f/cnt got %b/%0d, required 1/1", o_f, o_cnt);
      end
   endtask

   task automatic test_mid_reset();
      edge_step(1'b0, 4'b0111);
      edge_step(1'b1, 4'b0111);
      n_checks++;
      if ({o_f, o_cnt, o_valid} !== 5'b0) begin
         n_fail++;
         $display("FAIL midreset_clr: f/cnt/vld got %b/%0d/%b, required 0/0/0", o_f, o_cnt, o_valid);
      end
      for (int k = 0; k < LAT; k++) edge_step(1'b0, 4'b0111);
      n_checks++;
      if ({o_f, o_cnt, o_valid} !== {1'b1, 3'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL midreset_resume: f/cnt/vld got %b/%0d/%b, required 1/3/1", o_f, o_cnt, o_valid);
      end
   endtask

   // Valid rise timing after reset, and single-vector latency.
   task automatic test_latency();
      edge_step(1'b1, 4'b0000);
      edge_step(1'b0, 4'b0001);
      n_checks++;
      if (o_valid !== (LAT == 1) || o_f !== (LAT == 1)) begin
         n_fail++;
         $display("FAIL latency_first: f/vld got %b/%b, required %b/%b", o_f, o_valid, LAT == 1, LAT == 1);
      end
      edge_step(1'b0, 4'b0000);
      n_checks++;
      if (o_valid !== 1'b1 || o_f !== (LAT == 2)) begin
         n_fail++;
         $display("FAIL latency_second: f/vld got %b/%b, required %b/1", o_f, o_valid, LAT == 2);
      end
   endtask

   // Random back-to-back vectors with occasional reset pulses.
   task automatic test_back_to_back();
      exp_t       e;
      logic [3:0] v;
      bit         r;
      for (int i = 0; i < 200; i++) begin
         v = 4'($urandom_range(0, 15));
         r = ($urandom_range(0, 15) == 0);
         edge_step(r, v);
         e = model();
         n_checks++;
         if ({o_f, o_cnt, o_valid} !== {e.f, e.cnt, e.vld}) begin
            n_fail++;
            $display("FAIL random[%0d]: f/cnt/vld got %b/%0d/%b, required %b/%0d/%b",
                     i, o_f, o_cnt, o_valid, e.f, e.cnt, e.vld);
         end
         n_checks++;
         if (o_f_comb !== 1'((popcnt(v) % 2))) begin
            n_fail++;
            $display("FAIL random_comb[%0d]: o_f_comb got %b, required %0d", i, o_f_comb, popcnt(v) % 2);
         end
      end
   endtask

   initial begin
      i_rst = 1'b1;
      {i_a, i_b, i_c, i_d} = 4'bxxxx;
      test_reset();
      test_count();
      test_comb_path();
      test_mid_reset();
      test_latency();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_xor4_gate_equation
